// File: rtl/ram_req_pkg.sv
// Shared definitions for the RAM requester and its neighbours (RAM
// controller, AXI-lite front end).
//   - Default address/data widths and controller timing.
//   - FSM state encoding.
//   - Small elaboration-time helper.
package ram_req_pkg;

  localparam int RR_ADDR_W    = 8;
  localparam int RR_DATA_W    = 8;
  localparam int RR_INIT_WAIT = 2;
  localparam int RR_OP_LAT    = 2;

  typedef enum logic [1:0] {
    S_INIT = 2'b00,
    S_IDLE = 2'b01,
    S_WAIT = 2'b10,
    S_RESP = 2'b11
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ram_req_timer.sv
// Loadable down-counter with a zero flag. It times both the startup
// interval and the per-operation wait in the RAM requester.
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - asynchronous active-low reset, loads RST_VAL
//   load_i     - load load_val_i (takes priority over dec_i)
//   load_val_i - value to load
//   dec_i      - decrement by one; the count holds at zero
//   zero_o     - count is zero
module ram_req_timer #(
  parameter int          W       = 2,
  parameter int unsigned RST_VAL = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= W'(RST_VAL);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ram_requester.sv
// Initiator-side sequencer for the single-port RAM controller. It takes
// one read/write command at a time from a valid/ready request channel,
// drives the controller pins with a one-clock enable pulse, waits for the
// operation latency, then presents the result on a valid/ready response
// channel.
// Ports:
//   clk, rst_n                        - clock and asynchronous active-low reset
//   req_valid/req_ready               - request handshake
//   req_write, req_addr, req_wdata    - command (wdata ignored for reads)
//   rsp_valid/rsp_ready               - response handshake
//   rsp_write, rsp_rdata              - command type echo and read data
//   mem_read_en, mem_write_en,
//   mem_address, mem_data_in          - controller command pins
//   mem_data_out                      - controller read data
//   busy                              - not idle
module ram_requester
  import ram_req_pkg::*;
#(
  parameter int ADDR_W    = RR_ADDR_W,
  parameter int DATA_W    = RR_DATA_W,
  parameter int INIT_WAIT = RR_INIT_WAIT,
  parameter int OP_LAT    = RR_OP_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              mem_read_en,
  output logic              mem_write_en,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              busy
);

  localparam int TW = $clog2(max_int(INIT_WAIT, OP_LAT) + 1);

  if (INIT_WAIT < 1 || OP_LAT < 2) begin : g_bad_param
    $error("ram_requester: INIT_WAIT must be >= 1 and OP_LAT must be >= 2");
  end

  state_e            state_q;
  logic              mem_read_en_q;
  logic              mem_write_en_q;
  logic [ADDR_W-1:0] mem_address_q;
  logic [DATA_W-1:0] mem_data_in_q;
  logic              rsp_valid_q;
  logic              rsp_write_q;
  logic [DATA_W-1:0] rsp_rdata_q;

  logic accept;
  logic tmr_dec;
  logic tmr_zero;

  assign accept  = (state_q == S_IDLE) && req_valid;
  assign tmr_dec = (state_q == S_INIT) || (state_q == S_WAIT);

  // The reset value covers the startup interval; re-entry into S_INIT
  // only happens through reset, so no explicit INIT load is needed.
  ram_req_timer #(
    .W       (TW),
    .RST_VAL (INIT_WAIT - 1)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (accept),
    .load_val_i (TW'(OP_LAT)),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_INIT;
      mem_read_en_q  <= 1'b0;
      mem_write_en_q <= 1'b0;
      mem_address_q  <= '0;
      mem_data_in_q  <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_write_q    <= 1'b0;
      rsp_rdata_q    <= '0;
    end else begin
      unique case (state_q)
        S_INIT: begin
          if (tmr_zero) begin
            state_q <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (req_valid) begin
            mem_write_en_q <= req_write;
            mem_read_en_q  <= !req_write;
            mem_address_q  <= req_addr;
            mem_data_in_q  <= req_wdata;
            rsp_write_q    <= req_write;
            state_q        <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Enables are one-clock pulses; address/data keep holding.
          mem_write_en_q <= 1'b0;
          mem_read_en_q  <= 1'b0;
          if (tmr_zero) begin
            // Write responses keep the previous read data.
            if (!rsp_write_q) begin
              rsp_rdata_q <= mem_data_out;
            end
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

  assign req_ready    = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign mem_read_en  = mem_read_en_q;
  assign mem_write_en = mem_write_en_q;
  assign mem_address  = mem_address_q;
  assign mem_data_in  = mem_data_in_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_write    = rsp_write_q;
  assign rsp_rdata    = rsp_rdata_q;

endmodule

// File: tb/tb_ram_requester.sv
// Self-checking bench for ram_requester with a simple RAM controller model
// attached and a transaction-level reference model of the requester.
module tb_ram_requester;

  localparam int IW = 2;
  localparam int OL = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_write;
  logic [7:0] rsp_rdata;
  logic       mem_read_en;
  logic       mem_write_en;
  logic [7:0] mem_address;
  logic [7:0] mem_data_in;
  logic [7:0] mem_data_out;
  logic       busy;

  always #5 clk = ~clk;

  ram_requester #(
    .ADDR_W    (8),
    .DATA_W    (8),
    .INIT_WAIT (IW),
    .OP_LAT    (OL)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_write    (rsp_write),
    .rsp_rdata    (rsp_rdata),
    .mem_read_en  (mem_read_en),
    .mem_write_en (mem_write_en),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out),
    .busy         (busy)
  );

  // RAM controller stand-in: samples enables on the edge, read data is
  // available one clock later and held.
  logic [7:0] bram [256];
  always @(posedge clk) begin
    if (mem_write_en) bram[mem_address] <= mem_data_in;
    if (mem_read_en)  mem_data_out <= bram[mem_address];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;
  int re_cnt   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: tracks edges since reset release, the age of the
  // in-flight command and whether a response is pending.
  int         init_edges;
  bit         m_busy;
  int         m_age;
  bit         m_wr;
  logic [7:0] m_addr;
  logic [7:0] m_wdata;
  logic [7:0] m_rdata;
  logic [7:0] m_exp_rd;
  bit         m_pend;
  bit         m_rdy;
  logic [7:0] ref_mem [256];

  task automatic mreset();
    init_edges = 0;
    m_busy = 1'b0; m_age = 0; m_wr = 1'b0; m_pend = 1'b0;
    m_addr = 8'h00; m_wdata = 8'h00; m_rdata = 8'h00; m_exp_rd = 8'h00;
  endtask

  task automatic mstep();
    m_rdy = (init_edges >= IW) && !m_busy && !m_pend;
    if (m_rdy && req_valid) begin
      m_busy = 1'b1; m_age = 0;
      m_wr = req_write; m_addr = req_addr; m_wdata = req_wdata;
      if (req_write) ref_mem[req_addr] = req_wdata;
      else           m_exp_rd = ref_mem[req_addr];
    end else if (m_busy) begin
      m_age++;
      if (m_age == OL + 1) begin
        m_busy = 1'b0;
        m_pend = 1'b1;
        if (!m_wr) m_rdata = m_exp_rd;
      end
    end else if (m_pend && rsp_ready) begin
      m_pend = 1'b0;
    end
    if (init_edges < IW) init_edges++;
  endtask

  initial begin
    mreset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) mreset();
      else        mstep();
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    logic e_rdy;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        e_rdy = rst_n && (init_edges >= IW) && !m_busy && !m_pend;
        chk("req_ready",    req_ready,    e_rdy);
        chk("busy",         busy,         !e_rdy);
        chk("mem_write_en", mem_write_en, m_busy && (m_age == 0) && m_wr);
        chk("mem_read_en",  mem_read_en,  m_busy && (m_age == 0) && !m_wr);
        chk("mem_address",  mem_address,  m_addr);
        chk("mem_data_in",  mem_data_in,  m_wdata);
        chk("rsp_valid",    rsp_valid,    m_pend);
        chk("rsp_write",    rsp_write,    m_wr);
        chk("rsp_rdata",    rsp_rdata,    m_rdata);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (mem_read_en) re_cnt++;
    end
  end

  // Callers are always between edges; returns just after the accept edge.
  task automatic do_op(input logic w, input logic [7:0] a, input logic [7:0] d, output int acc);
    bit ok;
    bit r;
    ok = 1'b0; acc = -1;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    for (int n = 0; n < 100 && !ok; n++) begin
      r = req_ready;
      @(posedge clk); #1;
      if (r) begin ok = 1'b1; acc = cyc; end
    end
    req_valid = 1'b0;
    if (!ok) chk("req_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_rsp(input bit rnd, output int rc, output logic [7:0] rd, output logic rw);
    bit got;
    bit t;
    bit done;
    got = 1'b0; done = 1'b0; rc = -1; rd = 8'h00; rw = 1'b0;
    for (int n = 0; n < 100 && !got; n++) begin
      if (rnd) rsp_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (rsp_valid) got = 1'b1;
    end
    if (!got) begin
      chk("rsp_timeout", 32'd0, 32'd1);
    end else begin
      rc = cyc; rd = rsp_rdata; rw = rsp_write;
      for (int n = 0; n < 100 && !done; n++) begin
        if (rnd) rsp_ready = 1'($urandom_range(0, 1));
        t = rsp_ready;
        @(posedge clk); #1;
        if (t) done = 1'b1;
      end
      if (!done) chk("rsp_hs_timeout", 32'd0, 32'd1);
    end
  endtask

  int         acc;
  int         rc;
  int         r0;
  int         accs [8];
  logic [7:0] rd;
  logic       rw;
  logic [7:0] shadow [8];
  logic       w;
  logic [2:0] a;
  logic [7:0] d;

  initial begin
    rst_n = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    req_addr = 8'h00; req_wdata = 8'h00; rsp_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    chk("rst_busy", busy, 1);
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_mem_we", mem_write_en, 0);
    @(negedge clk); @(negedge clk); #1 rst_n = 1'b1;

    // Startup interval
    @(posedge clk); #1 chk("init_e1_ready", req_ready, 0);
    @(posedge clk); #1 chk("init_e2_ready", req_ready, 1);
    chk("init_e2_busy", busy, 0);

    // Write 0x12 <- 0xA5
    do_op(1'b1, 8'h12, 8'hA5, acc);
    chk("wr_we", mem_write_en, 1);
    chk("wr_re", mem_read_en, 0);
    chk("wr_addr", mem_address, 8'h12);
    chk("wr_data", mem_data_in, 8'hA5);
    wait_rsp(1'b0, rc, rd, rw);
    chk("wr_rsp_latency", rc - acc, 3);
    chk("wr_rsp_write", rw, 1);

    // Read 0x12
    r0 = re_cnt;
    do_op(1'b0, 8'h12, 8'h00, acc);
    chk("rd_re", mem_read_en, 1);
    wait_rsp(1'b0, rc, rd, rw);
    chk("rd_data", rd, 8'hA5);
    chk("rd_rsp_write", rw, 0);
    chk("rd_re_pulses", re_cnt - r0, 1);

    // Back-pressured response
    rsp_ready = 1'b0;
    do_op(1'b0, 8'h12, 8'h00, acc);
    for (int n = 0; n < 20 && !rsp_valid; n++) begin
      @(posedge clk); #1;
    end
    chk("bp_rsp_seen", rsp_valid, 1);
    repeat (10) begin
      @(posedge clk); #1;
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rdata", rsp_rdata, 8'hA5);
      chk("bp_ready", req_ready, 0);
      chk("bp_we", mem_write_en, 0);
      chk("bp_re", mem_read_en, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", rsp_valid, 0);
    chk("bp_release_ready", req_ready, 1);

    // Reset while waiting on the controller
    do_op(1'b0, 8'h12, 8'h00, acc);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_addr", mem_address, 0);
    chk("mid_rst_busy", busy, 1);
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_rsp_write", rsp_write, 0);
    @(negedge clk); @(negedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1 chk("reinit_e1_ready", req_ready, 0);
    @(posedge clk); #1 chk("reinit_e2_ready", req_ready, 1);
    do_op(1'b0, 8'h12, 8'h00, acc);
    wait_rsp(1'b0, rc, rd, rw);
    chk("reinit_rd_data", rd, 8'hA5);

    // Back-to-back throughput with rsp_ready held high
    for (int i = 0; i < 4; i++) begin
      do_op(1'b1, 8'(i), 8'(8'h10 + i), accs[i]);
      wait_rsp(1'b0, rc, rd, rw);
    end
    for (int i = 0; i < 4; i++) begin
      do_op(1'b0, 8'(i), 8'h00, accs[4 + i]);
      wait_rsp(1'b0, rc, rd, rw);
      chk("b2b_rd_data", rd, 8'(8'h10 + i));
    end
    for (int i = 1; i < 8; i++) begin
      chk("b2b_accept_spacing", accs[i] - accs[i - 1], 5);
    end

    // Randomized traffic with random response back-pressure
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom_range(0, 255));
      shadow[i] = d;
      do_op(1'b1, 8'(i), d, acc);
      wait_rsp(1'b1, rc, rd, rw);
    end
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      w = 1'($urandom_range(0, 1));
      a = 3'($urandom_range(0, 7));
      d = 8'($urandom_range(0, 255));
      do_op(w, {5'b0, a}, d, acc);
      wait_rsp(1'b1, rc, rd, rw);
      chk("rnd_rsp_write", rw, w);
      if (w) shadow[a] = d;
      else   chk("rnd_rd_data", rd, shadow[a]);
    end
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
